// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helpers for sync_fifo_param.
package fifo_pkg;
  localparam int DEF_AE_THRESH = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lvl_w(input int depth_bits);
    return depth_bits + 1;
  endfunction
  function automatic int def_af(input int depth_bits);
    return (1 << depth_bits) - 2;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: unreset storage array, synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
)(
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_BITS];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with fill level, threshold flags, FWFT/registered read and sticky errors.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_BITS = 4,
  parameter int AF_THRESH  = def_af(DEPTH_BITS),
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter bit FWFT       = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full_flag,
  output logic                  empty_flag,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int LW = lvl_w(DEPTH_BITS);
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << DEPTH_BITS);
  localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);

  if (DEPTH_BITS < 2 || DEPTH_BITS > 10) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH_BITS must be 2..10");
  end
  if (AF_THRESH < 0 || AF_THRESH > (1 << DEPTH_BITS)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= (1 << DEPTH_BITS)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be below DEPTH");
  end

  logic [DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level, w_level_nxt;
  logic                  r_full, r_empty, r_af, r_ae, r_ov, r_un;
  logic                  w_wr_acc, w_rd_acc;
  logic [DATA_WIDTH-1:0] w_mem_rd;

  // no bypass: a full FIFO refuses writes and an empty one refuses reads regardless of the other port
  assign w_wr_acc    = wr_en & ~r_full;
  assign w_rd_acc    = rd_en & ~r_empty;
  assign w_level_nxt = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= (AF_L == '0);
      r_ae     <= 1'b1;
      r_ov     <= 1'b0;
      r_un     <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(w_wr_acc);
      r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(w_rd_acc);
      r_level  <= w_level_nxt;
      r_full   <= w_level_nxt == DEPTH_L;
      r_empty  <= w_level_nxt == '0;
      r_af     <= w_level_nxt >= AF_L;
      r_ae     <= w_level_nxt <= AE_L;
      r_ov     <= (wr_en & r_full) | (r_ov & ~clr_err);
      r_un     <= (rd_en & r_empty) | (r_un & ~clr_err);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (DEPTH_BITS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rd)
  );

  if (FWFT) begin : g_fwft
    assign rd_data  = w_mem_rd;
    assign rd_valid = ~r_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_data  <= w_rd_acc ? w_mem_rd : r_rd_data;
        r_rd_valid <= w_rd_acc;
      end
    end
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end

  assign full_flag    = r_full;
  assign empty_flag   = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign level        = r_level;
  assign overflow     = r_ov;
  assign underflow    = r_un;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for FWFT (8-bit) and registered-read (16-bit) instances.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 0, rd_en = 0, clr_err = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data0;
  logic       rd_valid0, full0, empty0, af0, ae0, ov0, un0;
  logic [4:0] level0;

  logic        wr_en1 = 0, rd_en1 = 0, clr_err1 = 0;
  logic [15:0] wr_data1 = 0;
  logic [15:0] rd_data1;
  logic        rd_valid1, full1, empty1, af1, ae1, ov1, un1;
  logic [4:0]  level1;

  sync_fifo_param u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full_flag(full0), .empty_flag(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_param #(.DATA_WIDTH(16), .FWFT(1'b0)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1), .clr_err(clr_err1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full_flag(full1), .empty_flag(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1), .overflow(ov1), .underflow(un1)
  );

  int n_pass = 0;
  int n_tot = 0;
  logic [7:0] q[$];
  int m_lvl = 0;
  logic m_ov = 0, m_un = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    chk("level", 32'(level0), 32'(m_lvl));
    chk("full", 32'(full0), 32'(m_lvl == 16));
    chk("empty", 32'(empty0), 32'(m_lvl == 0));
    chk("almost_full", 32'(af0), 32'(m_lvl >= 14));
    chk("almost_empty", 32'(ae0), 32'(m_lvl <= 2));
    chk("overflow", 32'(ov0), 32'(m_ov));
    chk("underflow", 32'(un0), 32'(m_un));
    chk("rd_valid", 32'(rd_valid0), 32'(m_lvl != 0));
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wa, ra;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    wa = w && (m_lvl < 16);
    ra = r && (m_lvl > 0);
    if (ra) chk("pop_data", 32'(rd_data0), 32'(q[0]));
    tick();
    m_ov = (w && m_lvl == 16) || (m_ov && !c);
    m_un = (r && m_lvl == 0) || (m_un && !c);
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    m_lvl = m_lvl + int'(wa) - int'(ra);
    wr_en = 0; rd_en = 0; clr_err = 0;
    check_state();
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    check_state();
    chk("u1_rst_valid", 32'(rd_valid1), 32'd0);
    chk("u1_rst_data", 32'(rd_data1), 32'd0);
    chk("u1_rst_empty", 32'(empty1), 32'd1);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b1, 8'hEF, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk("drain_order", 32'(rd_data0), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    rst = 1; wr_en = 1; wr_data = 8'h77;
    tick();
    rst = 0; wr_en = 0;
    q.delete();
    m_lvl = 0; m_ov = 0; m_un = 0;
    check_state();
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("after_rst_data", 32'(rd_data0), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    wr_en1 = 1; wr_data1 = 16'hBEEF;
    tick();
    wr_en1 = 0;
    chk("u1_not_empty", 32'(empty1), 32'd0);
    chk("u1_no_valid_before_read", 32'(rd_valid1), 32'd0);
    rd_en1 = 1;
    #2;
    chk("u1_no_early_valid", 32'(rd_valid1), 32'd0);
    chk("u1_no_early_data", 32'(rd_data1), 32'd0);
    tick();
    rd_en1 = 0;
    chk("u1_valid", 32'(rd_valid1), 32'd1);
    chk("u1_data", 32'(rd_data1), 32'hBEEF);
    chk("u1_empty_after", 32'(empty1), 32'd1);
    tick();
    chk("u1_valid_pulse", 32'(rd_valid1), 32'd0);
    chk("u1_data_hold", 32'(rd_data1), 32'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised byte/word FIFO; successor to the UART dual-clock FIFO for blocks where producer and consumer share one clock (UART TX/RX staging, APB-side buffering). It adds configurable data width and depth, a fill-level output, programmable almost-full/almost-empty thresholds, a selectable read mode (first-word-fall-through or registered) and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8, bits per entry
- DEPTH_BITS, 4, log2 of depth; DEPTH = 2**DEPTH_BITS, legal 2..10
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read (1-cycle latency)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request / pop
- clr_err  in  1  clears overflow and underflow
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data is valid
- full_flag  out  1  level == DEPTH
- empty_flag  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  DEPTH_BITS+1  current entry count, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr, rd_ptr: DEPTH_BITS wide, wrap naturally modulo DEPTH; level is the authoritative occupancy register.
- Write accepted iff wr_en && !full_flag: store at wr_ptr, wr_ptr+1.
- Read accepted iff rd_en && !empty_flag: rd_ptr+1.
- Simultaneous accepted write and read: level unchanged. When full, write is refused even if a read is accepted in the same cycle; when empty, read is refused even if a write is accepted (no bypass).
- level next = level + wr_acc - rd_acc; never leaves 0..DEPTH.
- All flags are registered, derived from next level, so they are valid the cycle after the causing edge.
- overflow set on wr_en && full_flag; underflow set on rd_en && empty_flag; cleared by clr_err; set wins over clr_err in the same cycle.
- FWFT=1: rd_data = mem[rd_ptr] (combinational read of storage), rd_valid = !empty_flag; rd_en pops current word.
- FWFT=0: on accepted read, rd_data <= mem[rd_ptr]; rd_valid pulses high for exactly one cycle after; rd_data holds last value otherwise.
- Reset: wr_ptr=rd_ptr=0, level=0, empty_flag=1, full_flag=0, almost_empty=1, almost_full=0 (1 if AF_THRESH==0), overflow=underflow=0, rd_valid=0, rd_data=0 (FWFT=0). Storage contents not reset. Reset mid-operation discards all entries; any concurrent wr_en/rd_en is ignored.

## Timing
- Write-to-read latency: word written at edge N is visible (FWFT) / poppable at edge N+1.
- FWFT=0 read latency: rd_en at edge N -> rd_data/rd_valid valid after edge N+1.
- Throughput: one write and one read per cycle sustained.
- full_flag asserts the cycle after the DEPTH-th write; empty_flag deasserts the cycle after first write.

## Structure
- Package fifo_pkg: clog2 function, default threshold constants, level width helper.
- Sub-module fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write port, asynchronous read port; control logic stays in top.
- Elaboration checks: AF_THRESH <= DEPTH, AE_THRESH < DEPTH.

## Test plan
- Reset then idle: level=0, empty_flag=1, almost_empty=1, full_flag=0, rd_valid=0, overflow=underflow=0.
- DEPTH_BITS=4: write 0x00..0x0F -> full_flag=1, level=16, almost_full from level 14; 17th write -> overflow=1, data unchanged; read all back in order 0x00..0x0F.
- Read on empty -> underflow=1, level stays 0; clr_err -> 0; clr_err with simultaneous empty read -> underflow stays 1.
- Half full (level=8), simultaneous wr/rd for 40 cycles with incrementing data -> level stays 8, pointers wrap, output order preserved.
- FWFT=0, DATA_WIDTH=16: write 0xBEEF, rd_en at edge N -> rd_valid=1 and rd_data=0xBEEF only after edge N+1, rd_valid=0 next cycle.
- Fill to level 5, assert rst with wr_en=1 -> next cycle level=0, empty_flag=1, subsequent write 0xA5 read back as 0xA5.
